// File: rtl/ibias_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ibias_ctrl_pkg
// Shared definitions for the bias-generator sequencer:
//   - ibias_state_e : 3-bit FSM state encoding (codes 6 and 7 are illegal)
//   - ibias_out_t   : bundle of the Moore outputs driven to the bias generator
//   - *_DEF         : default cycle counts for the sequencer parameters
//   - decode_outputs: maps a state to its Moore output values
// ---------------------------------------------------------------------------
package ibias_ctrl_pkg;

    typedef enum logic [2:0] {
        StOff    = 3'd0,
        StStart  = 3'd1,
        StWaitBg = 3'd2,
        StSwitch = 3'd3,
        StReady  = 3'd4,
        StFault  = 3'd5
    } ibias_state_e;

    typedef struct packed {
        logic ena;    // bias generator enable
        logic sel;    // 0 = startup source, 1 = bandgap-referenced source
        logic rdy;    // bias settled on the referenced source
        logic fault;  // bandgap never came good
    } ibias_out_t;

    localparam int unsigned STARTUP_CYC_DEF = 16;
    localparam int unsigned BG_TIMEOUT_DEF  = 255;
    localparam int unsigned SETTLE_CYC_DEF  = 8;

    function automatic ibias_out_t decode_outputs(input ibias_state_e st);
        ibias_out_t o;
        o = '0;
        case (st)
            StOff:    o = '0;
            StStart:  o = '{ena: 1'b1, sel: 1'b0, rdy: 1'b0, fault: 1'b0};
            StWaitBg: o = '{ena: 1'b1, sel: 1'b0, rdy: 1'b0, fault: 1'b0};
            StSwitch: o = '{ena: 1'b1, sel: 1'b1, rdy: 1'b0, fault: 1'b0};
            StReady:  o = '{ena: 1'b1, sel: 1'b1, rdy: 1'b1, fault: 1'b0};
            StFault:  o = '{ena: 1'b1, sel: 1'b0, rdy: 1'b0, fault: 1'b1};
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/ibias_ctrl_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single-bit level crossing into the i_clk domain.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, both flops clear to 0
//   i_d     : asynchronous input level
//   o_q     : synchronized level, two i_clk edges after i_d settles
// ---------------------------------------------------------------------------
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ibias_ctrl.sv
// ---------------------------------------------------------------------------
// ibias_ctrl
// Power-up sequencer for the analog bias generator. Brings the bias up on the
// internal startup source, waits for the bandgap reference to be good, moves
// to the bandgap-referenced source and flags bias_rdy once it has settled.
// A bandgap that never comes good latches fault until en is dropped.
// Ports:
//   clk       : block clock
//   rst_n     : asynchronous active-low reset
//   en        : bias request (synchronous to clk)
//   bg_ok     : bandgap-good, asynchronous, synchronized internally
//   ibias_ena : bias generator enable
//   isrc_sel  : 0 = startup source, 1 = bandgap-referenced source
//   bias_rdy  : bias is on the referenced source and settled
//   fault     : bandgap timeout, sticky until en falls
//   state     : current FSM state code (debug/test)
// All outputs are registered and decoded from the next state, so they change
// on the same edge as the state register.
// ---------------------------------------------------------------------------
module ibias_ctrl
    import ibias_ctrl_pkg::*;
#(
    parameter int unsigned STARTUP_CYC = STARTUP_CYC_DEF,
    parameter int unsigned BG_TIMEOUT  = BG_TIMEOUT_DEF,
    parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       bg_ok,
    output logic       ibias_ena,
    output logic       isrc_sel,
    output logic       bias_rdy,
    output logic       fault,
    output logic [2:0] state
);

    // Reload values: a state loaded with N-1 lasts exactly N cycles because
    // the exit is taken on the edge where the counter is already 0.
    localparam logic [CNT_W-1:0] LD_START  = CNT_W'(STARTUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_BG     = CNT_W'(BG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYC - 1);

    logic         w_bg_ok_s;
    ibias_state_e r_state;
    ibias_state_e w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_dec;
    logic         w_cnt_zero;
    ibias_out_t   r_out;
    ibias_out_t   w_out_nxt;

    sync2 u_sync_bg_ok (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (bg_ok),
        .o_q     (w_bg_ok_s)
    );

    assign w_cnt_zero = (r_cnt == '0);
    // Saturating decrement: the counter never wraps below zero.
    assign w_cnt_dec  = w_cnt_zero ? '0 : r_cnt - 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;

        if (!en) begin
            // Dropping the request wins over everything, including FAULT.
            w_state_nxt = StOff;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                StOff: begin
                    w_state_nxt = StStart;
                    w_cnt_nxt   = LD_START;
                end
                StStart: begin
                    if (w_cnt_zero) begin
                        w_state_nxt = StWaitBg;
                        w_cnt_nxt   = LD_BG;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
                StWaitBg: begin
                    // A good bandgap on the final cycle still beats the timeout.
                    if (w_bg_ok_s) begin
                        w_state_nxt = StSwitch;
                        w_cnt_nxt   = LD_SETTLE;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = StFault;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
                StSwitch: begin
                    if (!w_bg_ok_s) begin
                        w_state_nxt = StWaitBg;
                        w_cnt_nxt   = LD_BG;
                    end else if (w_cnt_zero) begin
                        w_state_nxt = StReady;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_dec;
                    end
                end
                StReady: begin
                    if (!w_bg_ok_s) begin
                        w_state_nxt = StWaitBg;
                        w_cnt_nxt   = LD_BG;
                    end
                end
                StFault: begin
                    w_state_nxt = StFault;
                    w_cnt_nxt   = '0;
                end
                default: begin
                    // Codes 6/7 are unreachable in normal operation; recover.
                    w_state_nxt = StOff;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        w_out_nxt = decode_outputs(w_state_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StOff;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    assign ibias_ena = r_out.ena;
    assign isrc_sel  = r_out.sel;
    assign bias_rdy  = r_out.rdy;
    assign fault     = r_out.fault;
    assign state     = r_state;

endmodule

// File: tb/tb_ibias_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ibias_ctrl
// Directed bench for ibias_ctrl with default parameters. A table of
// {en, bg_ok, edges to advance, expected outputs} rows walks the main
// sequences; hand-written sequences cover async reset and the last-cycle
// bandgap race against the timeout.
// ---------------------------------------------------------------------------
module tb_ibias_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       bg_ok;
    logic       ibias_ena;
    logic       isrc_sel;
    logic       bias_rdy;
    logic       fault;
    logic [2:0] state;

    int n_checks;
    int n_fail;

    ibias_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bg_ok     (bg_ok),
        .ibias_ena (ibias_ena),
        .isrc_sel  (isrc_sel),
        .bias_rdy  (bias_rdy),
        .fault     (fault),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       en;
        logic       bg;
        int         n;
        logic [2:0] st;
        logic       ena;
        logic       sel;
        logic       rdy;
        logic       flt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input logic e, input logic b, input int n,
                                input logic [2:0] st, input logic ena, input logic sel,
                                input logic rdy, input logic flt);
        vec_t v;
        v.name = nm; v.en = e; v.bg = b; v.n = n;
        v.st = st; v.ena = ena; v.sel = sel; v.rdy = rdy; v.flt = flt;
        vecs.push_back(v);
    endfunction

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [2:0] st, input logic ena,
                         input logic sel, input logic rdy, input logic flt);
        logic [6:0] act;
        logic [6:0] exp;
        act = {state, ibias_ena, isrc_sel, bias_rdy, fault};
        exp = {st, ena, sel, rdy, flt};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ena/sel/rdy/fault=%b, required state=%0d ena/sel/rdy/fault=%b",
                     nm, act[6:4], act[3:0], exp[6:4], exp[3:0]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        bg_ok    = 1'b1;

        #2;
        check("reset_state", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check("off_after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Power-up with bg_ok held high: E, E+16 WAIT_BG, E+17 SWITCH, E+25 READY.
        add("start_at_E",        1, 1, 1,  3'd1, 1, 0, 0, 0);
        add("start_E15",         1, 1, 15, 3'd1, 1, 0, 0, 0);
        add("waitbg_E16",        1, 1, 1,  3'd2, 1, 0, 0, 0);
        add("switch_E17",        1, 1, 1,  3'd3, 1, 1, 0, 0);
        add("switch_E24",        1, 1, 7,  3'd3, 1, 1, 0, 0);
        add("ready_E25",         1, 1, 1,  3'd4, 1, 1, 1, 0);
        // bg_ok drop in READY: seen after sync, exit on the third edge.
        add("ready_bgdrop_2",    1, 0, 2,  3'd4, 1, 1, 1, 0);
        add("waitbg_bgdrop_3",   1, 0, 1,  3'd2, 1, 0, 0, 0);
        add("waitbg_bgrise_2",   1, 1, 2,  3'd2, 1, 0, 0, 0);
        add("switch_bgrise_3",   1, 1, 1,  3'd3, 1, 1, 0, 0);
        add("switch_bgrise_10",  1, 1, 7,  3'd3, 1, 1, 0, 0);
        add("ready_bgrise_11",   1, 1, 1,  3'd4, 1, 1, 1, 0);
        add("en_drop_ready",     0, 1, 1,  3'd0, 0, 0, 0, 0);
        // en drop in SWITCH.
        add("restart_start",     1, 1, 1,  3'd1, 1, 0, 0, 0);
        add("restart_switch",    1, 1, 17, 3'd3, 1, 1, 0, 0);
        add("en_drop_switch",    0, 1, 1,  3'd0, 0, 0, 0, 0);
        // bg_ok drop in SWITCH, then timeout to FAULT, sticky, cleared by en.
        add("sw2_start",         1, 1, 1,  3'd1, 1, 0, 0, 0);
        add("sw2_switch",        1, 1, 17, 3'd3, 1, 1, 0, 0);
        add("sw2_bgdrop_2",      1, 0, 2,  3'd3, 1, 1, 0, 0);
        add("sw2_waitbg",        1, 0, 1,  3'd2, 1, 0, 0, 0);
        add("sw2_waitbg_254",    1, 0, 254, 3'd2, 1, 0, 0, 0);
        add("sw2_fault_255",     1, 0, 1,  3'd5, 1, 0, 0, 1);
        add("fault_sticky",      1, 1, 5,  3'd5, 1, 0, 0, 1);
        add("en_drop_fault",     0, 1, 1,  3'd0, 0, 0, 0, 0);
        // bg_ok low from the outset: WAIT_BG at E+16, FAULT at E+16+255.
        add("bg0_off",           0, 0, 3,  3'd0, 0, 0, 0, 0);
        add("bg0_start",         1, 0, 1,  3'd1, 1, 0, 0, 0);
        add("bg0_start_15",      1, 0, 15, 3'd1, 1, 0, 0, 0);
        add("bg0_waitbg_16",     1, 0, 1,  3'd2, 1, 0, 0, 0);
        add("bg0_waitbg_270",    1, 0, 254, 3'd2, 1, 0, 0, 0);
        add("bg0_fault_271",     1, 0, 1,  3'd5, 1, 0, 0, 1);
        add("bg0_en_drop",       0, 0, 1,  3'd0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            en    = vecs[i].en;
            bg_ok = vecs[i].bg;
            tick(vecs[i].n);
            check(vecs[i].name, vecs[i].st, vecs[i].ena, vecs[i].sel, vecs[i].rdy, vecs[i].flt);
        end

        // Async reset between edges in START: outputs clear with no clock edge.
        en    = 1'b1;
        bg_ok = 1'b1;
        tick(5);
        check("rst_pre_start", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        check("rst_held", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        tick(1);
        check("rst_restart_start", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(16);
        check("rst_restart_waitbg", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        check("rst_restart_switch", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);

        // bg_ok_s rises exactly on the last WAIT_BG cycle: SWITCH, not FAULT.
        en    = 1'b0;
        bg_ok = 1'b0;
        tick(3);
        en = 1'b1;
        tick(1);
        tick(16);
        check("last_waitbg_entry", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(252);
        bg_ok = 1'b1;   // synced at W+254, seen by the FSM on edge W+255
        tick(2);
        check("last_waitbg_w254", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        check("last_waitbg_switch", 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
